// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - single-port memory arbiter and access sequencer for fetch and load/store paths
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_done) and byte address
//   if_rdata/if_done/if_err  fetched word, one-cycle completion pulse, error flag
//   d_req/d_wr/d_addr        data request (held until d_done), store select, byte address
//   d_wdata/d_size/d_sz_ex   right-aligned store data, access size, sign-extend select
//   d_rdata/d_done/d_err     extended load data, one-cycle completion pulse, error flag
//   busy                     arbiter is not idle
//   mem_req..mem_wdata       request to the shared memory, held until mem_ack
//   mem_rdata/mem_ack        memory read word and completion
module mem_port_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_done,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_size,
    input  logic                  d_sz_ex,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  d_err,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    // Value of the wait counter during the last BUSY cycle allowed before timeout.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t          state;
    logic            own_d;
    logic [1:0]      lat_lo;
    logic [1:0]      lat_size;
    logic            lat_wr;
    logic            lat_sx;
    logic [15:0]     wait_cnt;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  req_wr;
    logic                  req_mis;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] ld_shift;
    logic [DATA_WIDTH-1:0] ld_ext;

    // Request selection in IDLE: data wins over fetch; a fetch behaves as a word load.
    always_comb begin
        req_addr  = d_req ? d_addr : if_addr;
        req_size  = d_req ? d_size : SZ_WORD;
        req_wr    = d_req & d_wr;
        req_mis   = 1'b0;
        req_be    = 4'b1111;
        req_wdata = d_wdata;
        case (req_size)
            SZ_BYTE: begin
                req_be    = 4'b0001 << req_addr[1:0];
                req_wdata = {4{d_wdata[7:0]}};
            end
            SZ_HALF: begin
                req_mis   = req_addr[0];
                req_be    = 4'b0011 << req_addr[1:0];
                req_wdata = {2{d_wdata[15:0]}};
            end
            SZ_WORD: begin
                req_mis   = (req_addr[1:0] != 2'b00);
            end
            default: begin
                req_mis   = 1'b1;
            end
        endcase
    end

    // Load lane extraction and extension from the word returned by memory.
    always_comb begin
        ld_shift = mem_rdata >> {lat_lo, 3'b000};
        case (lat_size)
            SZ_BYTE: ld_ext = {{24{lat_sx & ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_ext = {{16{lat_sx & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            own_d     <= 1'b0;
            lat_lo    <= 2'b00;
            lat_size  <= 2'b00;
            lat_wr    <= 1'b0;
            lat_sx    <= 1'b0;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            if_rdata  <= '0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            d_rdata   <= '0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req || if_req) begin
                        own_d    <= d_req;
                        lat_lo   <= req_addr[1:0];
                        lat_size <= req_size;
                        lat_wr   <= req_wr;
                        lat_sx   <= d_sz_ex;
                        wait_cnt <= '0;
                        if (req_mis) begin
                            // Rejected without touching memory.
                            state <= RESP;
                            if (d_req) begin
                                d_done  <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                if_done  <= 1'b1;
                                if_err   <= 1'b1;
                                if_rdata <= '0;
                            end
                        end else begin
                            state     <= BUSY;
                            mem_req   <= 1'b1;
                            mem_wr    <= req_wr;
                            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be    <= req_be;
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_wr  <= 1'b0;
                        mem_be  <= 4'b0000;
                        if (own_d) begin
                            d_done  <= 1'b1;
                            d_err   <= 1'b0;
                            d_rdata <= lat_wr ? '0 : ld_ext;
                        end else begin
                            if_done  <= 1'b1;
                            if_err   <= 1'b0;
                            if_rdata <= mem_rdata;
                        end
                    end else if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
                        // Hung memory: abandon the access and report an error.
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_wr  <= 1'b0;
                        mem_be  <= 4'b0000;
                        if (own_d) begin
                            d_done  <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            if_done  <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    if_done  <= 1'b0;
                    if_err   <= 1'b0;
                    if_rdata <= '0;
                    d_done   <= 1'b0;
                    d_err    <= 1'b0;
                    d_rdata  <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
